// File: rtl/serial_edge_transmitter.sv
// Parallel-to-serial transmitter. It drives an Sclk/Sdata pair for a positive-edge shift-register receiver.
// Sdata only changes while Sclk is low, so every Sclk rise sees CLK_DIV cycles of setup and hold.
module serial_edge_transmitter #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data_in,
    output logic             Sclk,
    output logic             Sdata,
    output logic             Frame,
    output logic             Busy,
    output logic             Done
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(WIDTH) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(WIDTH);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("serial_edge_transmitter: WIDTH must be >= 1");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("serial_edge_transmitter: CLK_DIV must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic [BIT_W-1:0] bits_left;
    logic [BIT_W-1:0] bits_left_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_reg_next;
    logic [WIDTH-1:0] shifted;
    logic             sclk_next;
    logic             sdata_next;
    logic             frame_next;
    logic             busy_next;
    logic             done_next;
    logic             phase_end;

    assign phase_end = (div == DIV_LAST);
    assign shifted   = shift_reg << 1;
    assign busy_next = (state_next != IDLE);

    // Every output is computed one cycle ahead and registered, so there is no input-to-output path.
    always_comb begin
        state_next     = state;
        div_next       = div;
        bits_left_next = bits_left;
        shift_reg_next = shift_reg;
        sclk_next      = Sclk;
        sdata_next     = Sdata;
        frame_next     = Frame;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                sclk_next  = 1'b0;
                sdata_next = 1'b0;
                frame_next = 1'b0;
                if (Load) begin
                    state_next     = SETUP;
                    div_next       = '0;
                    bits_left_next = BIT_FULL;
                    shift_reg_next = Data_in;
                    sdata_next     = Data_in[WIDTH-1];
                    frame_next     = 1'b1;
                end
            end

            SETUP, LOW: begin
                if (phase_end) begin
                    state_next = HIGH;
                    div_next   = '0;
                    sclk_next  = 1'b1;
                end else begin
                    div_next = div + 1'b1;
                end
            end

            HIGH: begin
                if (phase_end) begin
                    div_next  = '0;
                    sclk_next = 1'b0;
                    // Sdata moves on the same edge that Sclk falls, which keeps the full hold window.
                    if (bits_left > BIT_ONE) begin
                        state_next     = LOW;
                        shift_reg_next = shifted;
                        bits_left_next = bits_left - BIT_ONE;
                        sdata_next     = shifted[WIDTH-1];
                    end else begin
                        state_next = IDLE;
                        sdata_next = 1'b0;
                        frame_next = 1'b0;
                        done_next  = 1'b1;
                    end
                end else begin
                    div_next = div + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state     <= IDLE;
            div       <= '0;
            bits_left <= '0;
            shift_reg <= '0;
            Sclk      <= 1'b0;
            Sdata     <= 1'b0;
            Frame     <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state     <= state_next;
            div       <= div_next;
            bits_left <= bits_left_next;
            shift_reg <= shift_reg_next;
            Sclk      <= sclk_next;
            Sdata     <= sdata_next;
            Frame     <= frame_next;
            Busy      <= busy_next;
            Done      <= done_next;
        end
    end

endmodule

// File: tb/tb_serial_edge_transmitter.sv
// Bench for serial_edge_transmitter. It runs two instances: CLK_DIV=4 (index 0) and CLK_DIV=1 (index 1).
// A frame-timing model predicts every output on every cycle. Literal checks pin the received words and the Done timing.
module tb_serial_edge_transmitter;

    localparam int W  = 8;
    localparam int D0 = 4;
    localparam int D1 = 1;

    logic         clk;
    logic         resetn;
    logic [1:0]   load;
    logic [W-1:0] din0;
    logic [W-1:0] din1;
    logic [1:0]   sclk;
    logic [1:0]   sdata;
    logic [1:0]   frame;
    logic [1:0]   busy;
    logic [1:0]   done;

    serial_edge_transmitter #(.WIDTH(W), .CLK_DIV(D0)) dut0 (
        .Clk(clk), .Resetn(resetn), .Load(load[0]), .Data_in(din0),
        .Sclk(sclk[0]), .Sdata(sdata[0]), .Frame(frame[0]), .Busy(busy[0]), .Done(done[0])
    );

    serial_edge_transmitter #(.WIDTH(W), .CLK_DIV(D1)) dut1 (
        .Clk(clk), .Resetn(resetn), .Load(load[1]), .Data_in(din1),
        .Sclk(sclk[1]), .Sdata(sdata[1]), .Frame(frame[1]), .Busy(busy[1]), .Done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model state: a frame accepted at edge st occupies cycles st .. st+2*W*D-1, and Done follows in the next cycle.
    bit           act [2];
    int           st  [2];
    logic [W-1:0] wd  [2];

    // Receiver-side observations: shift register clocked by Sclk, plus event counters.
    logic [W-1:0] rx    [2];
    int           rises [2];
    int           dn    [2];
    int           ldone [2];
    int           pdone [2];
    int           fcyc  [2];
    int           lfall [2];
    int           gap   [2];
    logic         psclk [2];
    logic         pframe[2];

    function automatic int divof(input int i);
        return (i == 0) ? D0 : D1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            logic [W-1:0] d;
            d = (i == 0) ? din0 : din1;
            if (!resetn) begin
                act[i] = 1'b0;
            end else if (load[i] && !(act[i] && cyc < st[i] + 2 * W * divof(i))) begin
                act[i] = 1'b1;
                st[i]  = cyc + 1;
                wd[i]  = d;
            end
        end
        cyc = cyc + 1;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic es, ed, ef, eb, eo;
            int   k;
            int   half;
            es = 1'b0; ed = 1'b0; ef = 1'b0; eb = 1'b0; eo = 1'b0;
            if (act[i]) begin
                k = cyc - st[i];
                if (k < 2 * W * divof(i)) begin
                    half = k / divof(i);
                    es   = (half % 2) == 1;
                    ed   = wd[i][W - 1 - half / 2];
                    ef   = 1'b1;
                    eb   = 1'b1;
                end else if (k == 2 * W * divof(i)) begin
                    eo = 1'b1;
                end
            end
            chk($sformatf("dut%0d Sclk", i),  {31'd0, sclk[i]},  {31'd0, es});
            chk($sformatf("dut%0d Sdata", i), {31'd0, sdata[i]}, {31'd0, ed});
            chk($sformatf("dut%0d Frame", i), {31'd0, frame[i]}, {31'd0, ef});
            chk($sformatf("dut%0d Busy", i),  {31'd0, busy[i]},  {31'd0, eb});
            chk($sformatf("dut%0d Done", i),  {31'd0, done[i]},  {31'd0, eo});

            if (sclk[i] === 1'b1 && psclk[i] === 1'b0) begin
                rx[i] = {rx[i][W-2:0], sdata[i]};
                rises[i]++;
            end
            psclk[i] = sclk[i];
            if (done[i] === 1'b1) begin
                dn[i]++;
                pdone[i] = ldone[i];
                ldone[i] = cyc;
            end
            if (frame[i] === 1'b1) fcyc[i]++;
            if (frame[i] === 1'b1 && pframe[i] === 1'b0) gap[i] = cyc - lfall[i];
            if (frame[i] === 1'b0 && pframe[i] === 1'b1) lfall[i] = cyc;
            pframe[i] = frame[i];
        end
    endtask

    // One cycle: inputs are sampled at the rising edge and outputs are compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_done(input int i, input int bound, input string name);
        int n0;
        n0 = dn[i];
        for (int c = 0; c < bound && dn[i] == n0; c++) tick();
        chk({name, " done seen"}, dn[i] - n0, 1);
    endtask

    initial begin
        int s;
        int s1;
        int n0;
        int r0;
        int f0;

        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; st[i] = 0; wd[i] = '0; rx[i] = '0; rises[i] = 0; dn[i] = 0;
            ldone[i] = 0; pdone[i] = 0; fcyc[i] = 0; lfall[i] = 0; gap[i] = 0;
            psclk[i] = 1'b0; pframe[i] = 1'b0;
        end

        // Reset held with Load asserted: nothing may start.
        resetn = 1'b0;
        load   = 2'b11;
        din0   = 8'hA5;
        din1   = 8'hA5;
        repeat (3) tick();
        chk("reset frame0", {31'd0, frame[0]}, 0);
        chk("reset busy1", {31'd0, busy[1]}, 0);
        load   = 2'b00;
        resetn = 1'b1;
        repeat (2) tick();
        chk("idle after reset frame0", {31'd0, frame[0]}, 0);

        // Single 8'hA5 frame, with an ignored Load of 8'h3C at frame cycle 20.
        n0 = dn[0]; r0 = rises[0]; f0 = fcyc[0];
        load[0] = 1'b1; din0 = 8'hA5;
        tick();
        s = cyc;
        load[0] = 1'b0;
        while (cyc < s + 19) tick();
        load[0] = 1'b1; din0 = 8'h3C;
        tick();
        load[0] = 1'b0;
        wait_done(0, 100, "a5");
        repeat (4) tick();
        chk("a5 word", {24'd0, rx[0]}, 32'hA5);
        chk("a5 done latency", ldone[0] - s, 64);
        chk("a5 rises", rises[0] - r0, 8);
        chk("a5 frame len", fcyc[0] - f0, 64);
        chk("a5 single done", dn[0] - n0, 1);

        // Back-to-back: the second Load is presented during the Done cycle.
        load[0] = 1'b1; din0 = 8'hF0;
        tick();
        s1 = cyc;
        load[0] = 1'b0;
        wait_done(0, 100, "f0");
        chk("f0 word", {24'd0, rx[0]}, 32'hF0);
        chk("f0 done latency", ldone[0] - s1, 64);
        load[0] = 1'b1; din0 = 8'h0F;
        tick();
        load[0] = 1'b0;
        wait_done(0, 100, "0f");
        chk("0f word", {24'd0, rx[0]}, 32'h0F);
        chk("b2b done spacing", ldone[0] - pdone[0], 65);
        chk("b2b frame gap", gap[0], 1);

        // Reset at frame cycle 30: no Done, then a clean 8'h81 frame.
        load[0] = 1'b1; din0 = 8'h55;
        tick();
        s = cyc;
        load[0] = 1'b0;
        while (cyc < s + 29) tick();
        resetn = 1'b0;
        tick();
        chk("midreset frame", {31'd0, frame[0]}, 0);
        chk("midreset sclk", {31'd0, sclk[0]}, 0);
        resetn = 1'b1;
        n0 = dn[0];
        repeat (70) tick();
        chk("midreset no done", dn[0] - n0, 0);
        load[0] = 1'b1; din0 = 8'h81;
        tick();
        s = cyc;
        load[0] = 1'b0;
        wait_done(0, 100, "81");
        chk("81 word", {24'd0, rx[0]}, 32'h81);
        chk("81 done latency", ldone[0] - s, 64);

        // CLK_DIV=1 boundary frames.
        r0 = rises[1]; f0 = fcyc[1];
        load[1] = 1'b1; din1 = 8'hFF;
        tick();
        s = cyc;
        load[1] = 1'b0;
        wait_done(1, 40, "ff");
        chk("ff word", {24'd0, rx[1]}, 32'hFF);
        chk("ff done latency", ldone[1] - s, 16);
        chk("ff frame len", fcyc[1] - f0, 16);
        chk("ff rises", rises[1] - r0, 8);
        repeat (3) tick();

        r0 = rises[1]; f0 = fcyc[1];
        load[1] = 1'b1; din1 = 8'h00;
        tick();
        s = cyc;
        load[1] = 1'b0;
        wait_done(1, 40, "00");
        chk("00 word", {24'd0, rx[1]}, 32'h00);
        chk("00 done latency", ldone[1] - s, 16);
        chk("00 frame len", fcyc[1] - f0, 16);
        chk("00 rises", rises[1] - r0, 8);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_edge_transmitter.md
Name: serial_edge_transmitter

Overview:
Parallel-to-serial transmitter that drives a clock/data pair (Sclk, Sdata) for a downstream positive-edge flip-flop shift-register receiver. It loads a WIDTH-bit word and shifts it out MSB first. Sdata changes only while Sclk is low, so it is stable across every Sclk rising edge. It sits between switch/register sources and an edge-triggered capture chain on the same board clock.

Parameters:
WIDTH, 8, number of data bits per frame (>=1)
CLK_DIV, 4, system Clk cycles per Sclk half-period (>=1)

Ports:
Clk  input  1  system clock; all state updates on rising edge
Resetn  input  1  synchronous active-low reset
Load  input  1  start request; sampled only in IDLE
Data_in  input  WIDTH  word to transmit; captured on the accepting Clk edge
Sclk  output  1  serial clock to receiver; rising edge = sample point
Sdata  output  1  serial data, MSB first
Frame  output  1  high for the whole transmission
Busy  output  1  high whenever state != IDLE
Done  output  1  one-cycle pulse after the last bit

Behaviour:
- Reset (Resetn=0 at a Clk edge): state=IDLE; Sclk=0, Sdata=0, Frame=0, Busy=0, Done=0; shift register, bit counter and divider cleared. Reset wins over every other input.
- All outputs are registered. No combinational path runs from inputs to outputs.
- States: IDLE, SETUP, HIGH, LOW.
- IDLE: Sclk=0, Sdata=0, Frame=0, Busy=0.
  - Load=1 at edge t: capture Data_in into shift_reg and set bits_left=WIDTH.
  - From t+1: state=SETUP, Frame=1, Busy=1, Sdata=Data_in[WIDTH-1], Sclk=0.
- SETUP: hold Sclk=0 for CLK_DIV cycles, then go to HIGH.
- HIGH: Sclk=1 for CLK_DIV cycles. Sdata is held.
  - At the end of HIGH, if bits_left>1: shift left by one, decrement bits_left, go to LOW. In the same cycle Sclk falls to 0 and Sdata takes the next bit.
  - At the end of HIGH, if bits_left==1: return to IDLE. In that cycle Sclk=0, Sdata=0, Frame=0, Busy=0, Done=1.
- LOW: Sclk=0 for CLK_DIV cycles, then go to HIGH.
- Timing:
  - Sdata setup and hold around each Sclk rise are CLK_DIV cycles each.
  - Sclk has exactly WIDTH rising edges per frame.
  - Frame stays high for exactly 2*WIDTH*CLK_DIV cycles.
  - Done is asserted in cycle t+1+2*WIDTH*CLK_DIV and lasts exactly one cycle.
- Load while Busy=1 is ignored, with no queuing. Data_in changes mid-frame have no effect.
- Back-to-back frames:
  - Load=1 in the cycle where Done=1 (state is already IDLE) is accepted.
  - Frame rises again on the next cycle, so Frame is low for exactly one cycle between frames.
- Reset mid-frame: the next edge forces reset values. Frame drops with no Done pulse and no partial-bit completion.
- Divider counter width is clog2(CLK_DIV)+1. Bit counter width is clog2(WIDTH)+1. Neither counter wraps beyond its terminal value.
- CLK_DIV=1: Sclk toggles every cycle and the frame takes 2*WIDTH cycles. All rules above still hold.

Test Plan:
- Reset: hold Resetn=0 for 3 cycles with Load=1 -> Sclk=Sdata=Frame=Busy=Done=0 throughout; no frame starts.
- Single frame, WIDTH=8, CLK_DIV=4, Data_in=8'hA5, Load pulse at cycle 0:
  - Frame high cycles 1..64; Sdata sampled at the 8 Sclk rises = 1,0,1,0,0,1,0,1.
  - Done=1 only at cycle 65.
  - Sdata constant 4 cycles before and after each rise.
- Busy ignore: during the 8'hA5 frame, pulse Load with Data_in=8'h3C at cycle 20 -> serial bits unchanged (still 8'hA5); exactly one Done.
- Back-to-back: Load=1 with 8'hF0, then Load=1 with 8'h0F in the Done cycle.
  - Frames carry 8'hF0 then 8'h0F.
  - Frame low for exactly 1 cycle between them; two Done pulses 65 cycles apart.
- Reset mid-frame: Resetn=0 at cycle 30 of a frame -> next cycle all outputs 0, no Done.
  - A subsequent Load of 8'h81 transmits correctly.
- Boundary with CLK_DIV=1:
  - 8'hFF -> Sdata=1 across all 8 rises; Frame 16 cycles.
  - 8'h00 -> Sdata=0 across all rises; Done at cycle 17 in both cases.
